level_meter_scheduler: RTL

Round-robin scheduler that shares one downstream level-display path between `channels` per-channel section_diff_buffer result streams.
- Accepts one peak-to-peak result at a time using a fair, scanning round-robin pointer.
- Keeps a per-channel peak-hold register with hold timer and linear decay.
- Emits {channel, level, peak} on a single valid/ready output stream.
- Sits between the per-channel diff buffers and the meter renderer/serializer.

---
 rtl/level_meter_pkg.sv | 32 +++
 rtl/level_meter_scheduler_peak_hold_update.sv | 46 ++++
 rtl/level_meter_scheduler.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/level_meter_pkg.sv
// Shared state encoding and arithmetic helpers for the level meter scheduler
// and its peak-hold datapath.
package level_meter_pkg;

  typedef enum logic [1:0] {
    ST_SCAN   = 2'd0,
    ST_UPDATE = 2'd1,
    ST_OUT    = 2'd2
  } state_e;

  // Bits needed to index n items; clog2(1) is 0.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

  // Unsigned subtract that floors at zero instead of wrapping.
  function automatic logic [31:0] sat_sub(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    if (a > b) begin
      r = a - b;
    end else begin
      r = 32'd0;
    end
    return r;
  endfunction

endpackage

// File: rtl/level_meter_scheduler_peak_hold_update.sv
// Next-state peak/hold computation for one channel: new peak capture,
// hold countdown, then linear decay that never drops below the current value.
module peak_hold_update
  import level_meter_pkg::*;
#(
  parameter int width      = 16,
  parameter int hold_bits  = 5,
  parameter int hold_count = 16,
  parameter int decay_step = 64
) (
  input  logic [width-1:0]     value,
  input  logic [width-1:0]     peak,
  input  logic [hold_bits-1:0] hold,
  input  logic                 clear,
  output logic [width-1:0]     next_peak,
  output logic [hold_bits-1:0] next_hold
);

  logic [width-1:0]     peak_s;
  logic [width-1:0]     decayed_s;
  logic [hold_bits-1:0] hold_s;

  // A clear arriving together with the update makes this channel start from zero.
  always_comb begin
    if (clear) begin
      peak_s = '0;
      hold_s = '0;
    end else begin
      peak_s = peak;
      hold_s = hold;
    end
    decayed_s = width'(sat_sub(32'(peak_s), 32'(decay_step)));
    next_peak = peak_s;
    next_hold = hold_s;
    if (value >= peak_s) begin
      next_peak = value;
      next_hold = hold_bits'(hold_count);
    end else if (hold_s != '0) begin
      next_hold = hold_s - hold_bits'(1);
    end else begin
      next_peak = (value > decayed_s) ? value : decayed_s;
      next_hold = '0;
    end
  end

endmodule

// File: rtl/level_meter_scheduler.sv
// Round-robin scheduler sharing one level/peak output stream between several
// diff-buffer result streams, with per-channel peak hold and decay.
module level_meter_scheduler
  import level_meter_pkg::*;
#(
  parameter int width        = 16,
  parameter int channels     = 2,
  parameter int channel_bits = 1,
  parameter int hold_count   = 16,
  parameter int decay_step   = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [channels-1:0]       i_valid,
  output logic [channels-1:0]       i_ready,
  input  logic [channels*width-1:0] i_value,
  input  logic                      i_clear,
  output logic                      o_valid,
  input  logic                      o_ready,
  output logic [channel_bits-1:0]   o_channel,
  output logic [width-1:0]          o_value,
  output logic [width-1:0]          o_peak
);

  localparam int hold_bits = (hold_count > 0) ? clog2(hold_count + 1) : 1;
  localparam logic [channel_bits-1:0] last_ch = channel_bits'(channels - 1);

  state_e                  state_q, state_d;
  logic [channel_bits-1:0] ptr_q, ptr_d;
  logic [channel_bits-1:0] cur_ch_q, cur_ch_d;
  logic [width-1:0]        cur_value_q, cur_value_d;
  logic [width-1:0]        peak_q [channels];
  logic [width-1:0]        peak_d [channels];
  logic [hold_bits-1:0]    hold_q [channels];
  logic [hold_bits-1:0]    hold_d [channels];
  logic                    o_valid_q, o_valid_d;
  logic [channel_bits-1:0] o_channel_q, o_channel_d;
  logic [width-1:0]        o_value_q, o_value_d;
  logic [width-1:0]        o_peak_q, o_peak_d;
  logic [width-1:0]        in_value_s [channels];
  logic [width-1:0]        upd_peak_s;
  logic [hold_bits-1:0]    upd_hold_s;

  // Explicit wrap so a non-power-of-two channel count never reaches an absent index.
  function automatic logic [channel_bits-1:0] next_ch(input logic [channel_bits-1:0] ch);
    logic [channel_bits-1:0] r;
    if (ch == last_ch) begin
      r = '0;
    end else begin
      r = ch + channel_bits'(1);
    end
    return r;
  endfunction

  for (genvar k = 0; k < channels; k++) begin : g_unpack
    assign in_value_s[k] = i_value[k*width +: width];
  end

  peak_hold_update #(
    .width      (width),
    .hold_bits  (hold_bits),
    .hold_count (hold_count),
    .decay_step (decay_step)
  ) u_peak_hold_update (
    .value     (cur_value_q),
    .peak      (peak_q[cur_ch_q]),
    .hold      (hold_q[cur_ch_q]),
    .clear     (i_clear),
    .next_peak (upd_peak_s),
    .next_hold (upd_hold_s)
  );

  // Only the scanned channel is offered ready, and only while scanning.
  always_comb begin
    i_ready = '0;
    if (state_q == ST_SCAN) begin
      i_ready[ptr_q] = 1'b1;
    end else begin
      i_ready = '0;
    end
  end

  // Scheduler next state, peak table update and output capture.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cur_ch_d    = cur_ch_q;
    cur_value_d = cur_value_q;
    o_valid_d   = o_valid_q;
    o_channel_d = o_channel_q;
    o_value_d   = o_value_q;
    o_peak_d    = o_peak_q;
    for (int k = 0; k < channels; k++) begin
      if (i_clear) begin
        peak_d[k] = '0;
        hold_d[k] = '0;
      end else begin
        peak_d[k] = peak_q[k];
        hold_d[k] = hold_q[k];
      end
    end
    case (state_q)
      ST_SCAN: begin
        if (i_valid[ptr_q]) begin
          cur_value_d = in_value_s[ptr_q];
          cur_ch_d    = ptr_q;
          state_d     = ST_UPDATE;
        end else begin
          ptr_d = next_ch(ptr_q);
        end
      end
      ST_UPDATE: begin
        peak_d[cur_ch_q] = upd_peak_s;
        hold_d[cur_ch_q] = upd_hold_s;
        o_valid_d        = 1'b1;
        o_channel_d      = cur_ch_q;
        o_value_d        = cur_value_q;
        o_peak_d         = upd_peak_s;
        state_d          = ST_OUT;
      end
      ST_OUT: begin
        // The served channel drops to lowest priority for the next scan.
        if (o_ready) begin
          o_valid_d = 1'b0;
          ptr_d     = next_ch(cur_ch_q);
          state_d   = ST_SCAN;
        end else begin
          state_d = ST_OUT;
        end
      end
      default: begin
        o_valid_d = 1'b0;
        ptr_d     = '0;
        state_d   = ST_SCAN;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_SCAN;
      ptr_q       <= '0;
      cur_ch_q    <= '0;
      cur_value_q <= '0;
      o_valid_q   <= 1'b0;
      o_channel_q <= '0;
      o_value_q   <= '0;
      o_peak_q    <= '0;
      for (int k = 0; k < channels; k++) begin
        peak_q[k] <= '0;
        hold_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cur_ch_q    <= cur_ch_d;
      cur_value_q <= cur_value_d;
      o_valid_q   <= o_valid_d;
      o_channel_q <= o_channel_d;
      o_value_q   <= o_value_d;
      o_peak_q    <= o_peak_d;
      peak_q      <= peak_d;
      hold_q      <= hold_d;
    end
  end

  assign o_valid   = o_valid_q;
  assign o_channel = o_channel_q;
  assign o_value   = o_value_q;
  assign o_peak    = o_peak_q;

endmodule
